// File: rtl/rx_packet_fifo_pkg.sv
// Shared types for the Rx store-and-forward packet FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// The entry struct lives in the top module because its width follows DATA_WIDTH.
package rx_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } wr_state_t;

    localparam int STAT_WIDTH = 32;

    // Bits per buffer entry: tlast + tkeep + tdata.
    function automatic int entry_bits(input int data_width);
        return data_width + data_width / 8 + 1;
    endfunction

endpackage

// File: rtl/rx_packet_fifo_if.sv
// AXIS bundle around the Rx packet FIFO: MAC-side s00 (no tready) and user-side m00.
// Latency: n/a (wires only).
// Backpressure: only the m00 side carries tready; the s00 side cannot be stalled.
interface rx_packet_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int DATA_NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0]  s00_axis_tdata;
    logic [DATA_NBYTES-1:0] s00_axis_tkeep;
    logic                   s00_axis_tvalid;
    logic                   s00_axis_tlast;
    logic                   s00_axis_tuser;

    logic [DATA_WIDTH-1:0]  m00_axis_tdata;
    logic [DATA_NBYTES-1:0] m00_axis_tkeep;
    logic                   m00_axis_tvalid;
    logic                   m00_axis_tready;
    logic                   m00_axis_tlast;

    // FIFO view: consumes s00, produces m00.
    modport slave (
        input  s00_axis_tdata, s00_axis_tkeep, s00_axis_tvalid, s00_axis_tlast, s00_axis_tuser,
        input  m00_axis_tready,
        output m00_axis_tdata, m00_axis_tkeep, m00_axis_tvalid, m00_axis_tlast
    );

    // Environment view: MAC drives s00, user logic sinks m00.
    modport master (
        output s00_axis_tdata, s00_axis_tkeep, s00_axis_tvalid, s00_axis_tlast, s00_axis_tuser,
        output m00_axis_tready,
        input  m00_axis_tdata, m00_axis_tkeep, m00_axis_tvalid, m00_axis_tlast
    );

endinterface

// File: rtl/rx_packet_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read (maps onto block RAM).
// Latency: read data appears one cycle after rd_en.
// Backpressure: none; rd_dat holds its value while rd_en is low.
module rx_packet_fifo_ram #(
    parameter int WIDTH      = 37,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_dat,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_dat
);

    logic [WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

    // Write port and registered read port; no reset so the array stays a RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_packet_fifo.sv
// Store-and-forward Rx packet FIFO: forwards only complete good frames, drops bad/overflowing ones.
// Latency: tvalid rises two edges after a good tlast is sampled into an empty FIFO.
// Backpressure: m00 honours tready with gapless output; s00 never stalls (overflow drops the frame).
// Optional stats counters are enabled with the RX_PACKET_FIFO_STATS_EN macro.
module rx_packet_fifo
    import rx_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH  = 32,
    parameter int  DEPTH       = 512,
    localparam int DATA_NBYTES = DATA_WIDTH / 8,
    localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    rx_packet_fifo_if.slave       axis,
    output logic                  drop_pulse,
    output logic [ADDR_WIDTH:0]   fifo_frames
`ifdef RX_PACKET_FIFO_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stat_good_frames,
    output logic [STAT_WIDTH-1:0] stat_bad_frames,
    output logic [STAT_WIDTH-1:0] stat_overflow_frames
`endif
);

    typedef struct packed {
        logic                   tlast;
        logic [DATA_NBYTES-1:0] tkeep;
        logic [DATA_WIDTH-1:0]  tdata;
    } fifo_entry_t;

    localparam int ENTRY_W = entry_bits(DATA_WIDTH);

    wr_state_t           state, state_nxt;
    logic [ADDR_WIDTH:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_WIDTH:0] commit_ptr, commit_ptr_nxt;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] used;
    logic                full;
    logic                mem_we;
    logic                commit_evt, bad_evt, ovf_evt;

    fifo_entry_t         wr_entry, rd_entry, out_entry;
    logic [ENTRY_W-1:0]  rd_raw;
    logic                avail, rd_en, s1_vld, out_vld, load_out, rd_last;

    // Occupancy uses registered pointers only, so a same-cycle read cannot rescue a full buffer.
    assign used = wr_ptr - rd_ptr;
    assign full = used[ADDR_WIDTH];

    assign wr_entry = '{tlast: axis.s00_axis_tlast,
                        tkeep: axis.s00_axis_tkeep,
                        tdata: axis.s00_axis_tdata};

    // Write FSM: speculative write, commit on good tlast, rewind on bad or overflowed frame.
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        mem_we         = 1'b0;
        commit_evt     = 1'b0;
        bad_evt        = 1'b0;
        ovf_evt        = 1'b0;
        if (axis.s00_axis_tvalid) begin
            case (state)
                IDLE, RECV: begin
                    if (full) begin
                        if (axis.s00_axis_tlast) begin
                            wr_ptr_nxt = commit_ptr;
                            ovf_evt    = 1'b1;
                            state_nxt  = IDLE;
                        end else begin
                            state_nxt  = DROP;
                        end
                    end else if (axis.s00_axis_tlast) begin
                        if (axis.s00_axis_tuser) begin
                            wr_ptr_nxt = commit_ptr;
                            bad_evt    = 1'b1;
                        end else begin
                            mem_we         = 1'b1;
                            wr_ptr_nxt     = wr_ptr + 1'b1;
                            commit_ptr_nxt = wr_ptr + 1'b1;
                            commit_evt     = 1'b1;
                        end
                        state_nxt = IDLE;
                    end else begin
                        mem_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + 1'b1;
                        state_nxt  = RECV;
                    end
                end
                DROP: begin
                    if (axis.s00_axis_tlast) begin
                        wr_ptr_nxt = commit_ptr;
                        ovf_evt    = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Write-side state, pointers and the registered drop pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            drop_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            drop_pulse <= bad_evt | ovf_evt;
        end
    end

    rx_packet_fifo_ram #(
        .WIDTH      (ENTRY_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_dat  (wr_entry),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_dat  (rd_raw)
    );

    assign rd_entry = fifo_entry_t'(rd_raw);

    // Two-stage read pipe: RAM output (s1) feeds the AXIS output register.
    // Only committed data is readable; a read is issued whenever s1 will be free next cycle.
    assign avail    = (rd_ptr != commit_ptr);
    assign load_out = s1_vld & (~out_vld | axis.m00_axis_tready);
    assign rd_en    = avail & (~s1_vld | load_out);
    assign rd_last  = out_vld & axis.m00_axis_tready & out_entry.tlast;

    // Read pointer, pipe valids and output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr    <= '0;
            s1_vld    <= 1'b0;
            out_vld   <= 1'b0;
            out_entry <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            s1_vld  <= rd_en | (s1_vld & ~load_out);
            out_vld <= load_out | (out_vld & ~axis.m00_axis_tready);
            if (load_out) begin
                out_entry <= rd_entry;
            end
        end
    end

    assign axis.m00_axis_tvalid = out_vld;
    assign axis.m00_axis_tdata  = out_entry.tdata;
    assign axis.m00_axis_tkeep  = out_entry.tkeep;
    assign axis.m00_axis_tlast  = out_entry.tlast;

    // Committed-frame count; a commit and a final-beat handshake in one cycle cancel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_frames <= '0;
        end else begin
            case ({commit_evt, rd_last})
                2'b10:   fifo_frames <= fifo_frames + 1'b1;
                2'b01:   fifo_frames <= fifo_frames - 1'b1;
                default: fifo_frames <= fifo_frames;
            endcase
        end
    end

`ifdef RX_PACKET_FIFO_STATS_EN
    // Saturating frame statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_good_frames     <= '0;
            stat_bad_frames      <= '0;
            stat_overflow_frames <= '0;
        end else begin
            if (commit_evt && stat_good_frames != '1) begin
                stat_good_frames <= stat_good_frames + 1'b1;
            end
            if (bad_evt && stat_bad_frames != '1) begin
                stat_bad_frames <= stat_bad_frames + 1'b1;
            end
            if (ovf_evt && stat_overflow_frames != '1) begin
                stat_overflow_frames <= stat_overflow_frames + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_packet_fifo.sv
// Directed bench for rx_packet_fifo with a beat scoreboard.
// Latency: n/a.
// Backpressure: tready driven high, low or toggling per test phase.
module tb_rx_packet_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    rx_packet_fifo_if #(.DATA_WIDTH(DW)) axis ();

    logic          drop_pulse;
    logic [AW:0]   fifo_frames;
`ifdef RX_PACKET_FIFO_STATS_EN
    logic [31:0]   stat_good_frames, stat_bad_frames, stat_overflow_frames;
`endif

    rx_packet_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .axis        (axis),
        .drop_pulse  (drop_pulse),
        .fifo_frames (fifo_frames)
`ifdef RX_PACKET_FIFO_STATS_EN
        ,
        .stat_good_frames     (stat_good_frames),
        .stat_bad_frames      (stat_bad_frames),
        .stat_overflow_frames (stat_overflow_frames)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int drops = 0;
    int tready_mode = 1;  // 0 low, 1 high, 2 toggle

    logic [36:0] exp_q[$];
    logic [36:0] mon_beat, want_beat, prev_beat;
    logic        prev_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready pattern, updated just after each rising edge.
    initial begin
        axis.m00_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0:       axis.m00_axis_tready = 1'b0;
                1:       axis.m00_axis_tready = 1'b1;
                default: axis.m00_axis_tready = ~axis.m00_axis_tready;
            endcase
        end
    end

    // Output monitor on the falling edge: hold rule, scoreboard pop, drop pulses.
    always @(negedge clk) begin
        mon_beat = {axis.m00_axis_tlast, axis.m00_axis_tkeep, axis.m00_axis_tdata};
        if (reset_n === 1'b1) begin
            if (drop_pulse === 1'b1) drops++;
            if (prev_stall) begin
                total++;
                assert (axis.m00_axis_tvalid === 1'b1 && mon_beat === prev_beat) else begin
                    bad++;
                    $error("FAIL hold: got vld=%b beat=%h want vld=1 beat=%h",
                           axis.m00_axis_tvalid, mon_beat, prev_beat);
                end
            end
            if (axis.m00_axis_tvalid === 1'b1 && axis.m00_axis_tready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $error("FAIL unexpected_beat: got %h want none", mon_beat);
                end else begin
                    want_beat = exp_q.pop_front();
                    assert (mon_beat === want_beat) else begin
                        bad++;
                        $error("FAIL beat: got %h want %h", mon_beat, want_beat);
                    end
                end
            end
            prev_stall = (axis.m00_axis_tvalid === 1'b1) && (axis.m00_axis_tready !== 1'b1);
            prev_beat  = mon_beat;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string tag, input int got, input int want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic last,
                              input logic user, input logic expect_out);
        @(posedge clk);
        #1;
        axis.s00_axis_tdata  = d;
        axis.s00_axis_tkeep  = k;
        axis.s00_axis_tlast  = last;
        axis.s00_axis_tuser  = user;
        axis.s00_axis_tvalid = 1'b1;
        if (expect_out) exp_q.push_back({last, k, d});
    endtask

    task automatic send_frame(input int n, input logic [31:0] base, input logic [3:0] last_keep,
                              input logic user, input logic expect_out);
        for (int i = 0; i < n; i++) begin
            drive_beat(base + 32'(i), (i == n - 1) ? last_keep : 4'hF, i == n - 1,
                       (i == n - 1) ? user : 1'b0, expect_out);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        axis.s00_axis_tvalid = 1'b0;
        axis.s00_axis_tlast  = 1'b0;
        axis.s00_axis_tuser  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        int k;
        int first_cyc;
        int d0;

        axis.s00_axis_tdata  = '0;
        axis.s00_axis_tkeep  = '0;
        axis.s00_axis_tvalid = 1'b0;
        axis.s00_axis_tlast  = 1'b0;
        axis.s00_axis_tuser  = 1'b0;
        reset_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tvalid", int'(axis.m00_axis_tvalid), 0);
        chk("rst_tdata", int'(axis.m00_axis_tdata), 0);
        chk("rst_tlast", int'(axis.m00_axis_tlast), 0);
        chk("rst_drop", int'(drop_pulse), 0);
        chk("rst_frames", int'(fifo_frames), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Single good frame: latency and frame count
        tready_mode = 1;
        send_frame(16, 32'h1, 4'h3, 1'b0, 1'b1);
        k = cyc;
        idle();
        @(negedge clk);
        chk("frames_after_commit", int'(fifo_frames), 1);
        first_cyc = -1;
        for (int i = 0; i < 10; i++) begin
            if (axis.m00_axis_tvalid === 1'b1) begin
                first_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("latency", first_cyc, k + 3);
        wait_drain("drain_single");
        chk("frames_after_read", int'(fifo_frames), 0);
        chk("drops_single", drops, 0);

        // Bad frame then good frame
        d0 = drops;
        send_frame(8, 32'h100, 4'hF, 1'b1, 1'b0);
        send_frame(4, 32'h200, 4'h1, 1'b0, 1'b1);
        idle();
        wait_drain("drain_bad");
        chk("drops_bad", drops - d0, 1);
`ifdef RX_PACKET_FIFO_STATS_EN
        chk("stat_bad", int'(stat_bad_frames), 1);
`endif

        // Overflow with the sink stalled
        tready_mode = 0;
        d0 = drops;
        send_frame(10, 32'h300, 4'hF, 1'b0, 1'b1);
        send_frame(10, 32'h400, 4'hF, 1'b0, 1'b0);
        idle();
        repeat (5) @(negedge clk);
        chk("drops_ovf", drops - d0, 1);
        chk("frames_ovf", int'(fifo_frames), 1);
        tready_mode = 1;
        wait_drain("drain_ovf");
        chk("frames_ovf_done", int'(fifo_frames), 0);
`ifdef RX_PACKET_FIFO_STATS_EN
        chk("stat_ovf", int'(stat_overflow_frames), 1);
`endif

        // Backpressure: three back-to-back frames, tready toggling
        tready_mode = 2;
        d0 = drops;
        send_frame(5, 32'h500, 4'hF, 1'b0, 1'b1);
        send_frame(5, 32'h600, 4'hF, 1'b0, 1'b1);
        send_frame(5, 32'h700, 4'hF, 1'b0, 1'b1);
        idle();
        wait_drain("drain_bp");
        chk("drops_bp", drops - d0, 0);

        // Wrap-around: 20 three-beat frames
        tready_mode = 1;
        d0 = drops;
        for (int f = 0; f < 20; f++) begin
            send_frame(3, 32'h1000 + 32'(f * 16), 4'hF, 1'b0, 1'b1);
        end
        idle();
        wait_drain("drain_wrap");
        chk("drops_wrap", drops - d0, 0);
        chk("frames_wrap", int'(fifo_frames), 0);
`ifdef RX_PACKET_FIFO_STATS_EN
        chk("stat_good", int'(stat_good_frames), 26);
`endif

        // Reset in the middle of a frame
        drive_beat(32'h800, 4'hF, 1'b0, 1'b0, 1'b0);
        drive_beat(32'h801, 4'hF, 1'b0, 1'b0, 1'b0);
        drive_beat(32'h802, 4'hF, 1'b0, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        axis.s00_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("midrst_tvalid", int'(axis.m00_axis_tvalid), 0);
        chk("midrst_tdata", int'(axis.m00_axis_tdata), 0);
        chk("midrst_frames", int'(fifo_frames), 0);
        chk("midrst_drop", int'(drop_pulse), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        send_frame(2, 32'h900, 4'h7, 1'b0, 1'b1);
        idle();
        wait_drain("drain_rst");
        chk("frames_rst", int'(fifo_frames), 0);
`ifdef RX_PACKET_FIFO_STATS_EN
        chk("stat_good_rst", int'(stat_good_frames), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_packet_fifo.md
Name: rx_packet_fifo

Overview:
- Store-and-forward packet FIFO directly downstream of the MAC Rx AXIS output, in the rx clock domain.
- Accepts the MAC's registered Rx stream, which has no tready, and releases only complete, error-free frames to the user-side AXIS master.
- Drops frames flagged bad by tuser and frames that overflow the buffer, so the user logic never sees partial or errored frames and may apply backpressure.

Parameters:
- DATA_WIDTH, 32, beat width in bits; 32 and 64 supported.
- DATA_NBYTES, DATA_WIDTH/8, localparam, tkeep width.
- DEPTH, 512, buffer entries (beats); must be a power of two, at least 16.
- ADDR_WIDTH, $clog2(DEPTH), localparam.

Ports:
- clk  in  1  Rx clock (the same clock as the MAC rx_clk).
- reset_n  in  1  Asynchronous, active-low reset.
- s00_axis_tdata  in  DATA_WIDTH  Rx beat from the MAC.
- s00_axis_tkeep  in  DATA_NBYTES  Byte enables; stored verbatim.
- s00_axis_tvalid  in  1  Beat valid. There is no tready: every valid beat is consumed or discarded.
- s00_axis_tlast  in  1  Last beat of the frame.
- s00_axis_tuser  in  1  Qualified on the tlast beat; 1 means the frame is bad (FCS or PHY error).
- m00_axis_tdata  out  DATA_WIDTH  Output beat.
- m00_axis_tkeep  out  DATA_NBYTES  Output byte enables.
- m00_axis_tvalid  out  1  Output valid.
- m00_axis_tready  in  1  Downstream ready.
- m00_axis_tlast  out  1  Last beat of the output frame.
- drop_pulse  out  1  Pulses high for one cycle per dropped frame.
- fifo_frames  out  ADDR_WIDTH+1  Number of committed frames not yet fully read.

Behaviour:
- Reset values:
  - All outputs are 0 while reset_n is low.
  - All pointers, counters and flags are cleared.
  - Reset mid-frame discards everything, including partial and committed frames.
- Storage:
  - Each entry holds {tlast, tkeep, tdata}.
  - Pointers are ADDR_WIDTH+1 bits, so the MSB distinguishes full from empty and wrap-around is natural.
  - Three pointers are kept: wr_ptr (speculative write), commit_ptr (end of the last good frame) and rd_ptr.
- Write state machine, states IDLE, RECV, DROP:
  - IDLE/RECV with a valid beat and the buffer not full (wr_ptr - rd_ptr < DEPTH): write the beat and increment wr_ptr.
  - Valid beat arriving while full: go to DROP. If that beat is also tlast, drop immediately and stay in IDLE.
  - tlast with tuser=0 and no overflow: set commit_ptr to wr_ptr+1 at the same edge; return to IDLE.
  - tlast with tuser=1: rewind wr_ptr to commit_ptr, pulse drop_pulse; return to IDLE.
  - DROP: discard beats until tlast, then rewind wr_ptr to commit_ptr, pulse drop_pulse; return to IDLE.
- Read side:
  - Readable data is bounded by commit_ptr, never by wr_ptr.
  - Memory read is registered (BRAM inferred), followed by a one-entry output register.
  - AXIS rules: tvalid does not drop and data is held stable until tready is seen high.
  - Gapless output when tready is held high and committed data is available.
- Latency: for a good frame whose tlast beat is sampled at edge E with an empty FIFO, m00_axis_tvalid rises after edge E+2.
- fifo_frames:
  - Increments at commit.
  - Decrements when a tlast beat handshakes on m00.
  - If both happen in the same cycle, the count is unchanged.
- Simultaneous events:
  - A read freeing an entry in the same cycle a beat arrives while full does not prevent the drop; "full" is evaluated on registered pointers.
  - Commit and read in the same cycle are both honoured.
- A frame longer than DEPTH beats is always dropped, as an overflow.
- Single-beat frames are legal.

Optional Feature:
- Macro: RX_PACKET_FIFO_STATS_EN.
- When defined, three 32-bit saturating output ports are added, all reset to 0:
  - stat_good_frames, incremented at commit.
  - stat_bad_frames, incremented on tuser drop.
  - stat_overflow_frames, incremented on overflow drop.
- When undefined, these ports and their counters are absent; drop_pulse remains.

Decomposition:
- Shared package (rx_fifo_pkg):
  - typedef for the write state enum {IDLE, RECV, DROP}.
  - packed struct fifo_entry_t {tlast, tkeep, tdata}.
- Natural sub-module: rx_packet_fifo_ram, a simple dual-port RAM with synchronous write and registered read, sized DEPTH × (DATA_WIDTH+DATA_NBYTES+1).

Test Plan:
- Single good frame:
  - Stimulus: 16 beats 0x00000001..0x00000010, tkeep 0xF, last beat tkeep 0x3, tuser 0, tready 1.
  - Response: identical 16 beats out; tvalid first high 2 cycles after tlast; fifo_frames 1→0.
- Bad frame followed by good frame:
  - Stimulus: 8-beat frame with tuser=1, then a 4-beat good frame.
  - Response: drop_pulse once; only the 4-beat frame is output; stat_bad_frames=1.
- Overflow:
  - Stimulus: DEPTH=16, tready=0, a 10-beat good frame, then a 10-beat frame.
  - Response: second frame dropped, drop_pulse once; after tready=1 only the first 10 beats are output; stat_overflow_frames=1.
- Backpressure:
  - Stimulus: three back-to-back 5-beat good frames, tready toggling 1010…
  - Response: all 15 beats in order; data stable while tvalid=1 and tready=0; tlast on beats 5, 10, 15.
- Wrap-around:
  - Stimulus: DEPTH=16, 20 consecutive 3-beat frames, tready=1.
  - Response: all 60 beats correct in order; no drops.
- Reset mid-frame:
  - Stimulus: assert reset_n=0 during beat 3 of a 6-beat frame, release, send a 2-beat good frame.
  - Response: outputs 0 during reset; only the 2-beat frame is output; fifo_frames=0 afterwards.
